b2_demux_1_3_stream: RTL and testbench

- Registered 1-to-3 stream demultiplexer, the inverse of the 3:1 mux family in the comb-mux lab.
- Routes a W-bit data word from one valid/ready input stream to one of three valid/ready output channels, selected by a 2-bit sel.
- Each output has a one-entry register slot, so a stalled channel does not block traffic to the other channels.
- Per-channel accepted-word counters are provided for lab observation.

---
 rtl/b2_demux_pkg.sv | 16 +
 rtl/b2_demux_slot.sv | 42 ++++
 rtl/b2_demux_1_3_stream.sv | 71 +++++++
 tb/tb_b2_demux_1_3_stream.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/b2_demux_pkg.sv
// Shared definitions for the 1-to-3 stream demultiplexer:
// channel indices, channel count and select encodings.
package b2_demux_pkg;

    localparam int NUM_CH = 3;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;

    // SEL_CH2 matches both 10 and 11 when used as a casez item
    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b1?;

endpackage

// File: rtl/b2_demux_slot.sv
// One-entry valid/ready register slot for a single output channel.
// Ports: clk, rst, i_push/i_data (load), i_pop (downstream ready),
//        o_valid/o_data (held word), o_can_push (slot free or draining).
module b2_demux_slot
    import b2_demux_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_can_push
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_pop;

    assign w_pop      = r_valid & i_pop;
    assign o_can_push = !r_valid | i_pop;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    // A push wins over a pop so a same-cycle push/pop keeps the slot full.
    // Data is left untouched on a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/b2_demux_1_3_stream.sv
// Registered 1-to-3 valid/ready stream demux with per-channel counters.
// Ports: clk, rst, in_valid/in_ready/in_data/in_sel (input stream),
//        out_valid/out_ready/out_data (3 channels), cnt0..cnt2 (accepts).
module b2_demux_1_3_stream
    import b2_demux_pkg::*;
#(
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [1:0]        in_sel,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic [3*W-1:0]    out_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2
);

    logic [1:0]        w_tgt;
    logic [NUM_CH-1:0] w_can_push;
    logic [NUM_CH-1:0] w_push;
    logic              w_acc;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];

    always_comb begin
        w_tgt = CH2;
        unique casez (in_sel)
            SEL_CH0: w_tgt = CH0;
            SEL_CH1: w_tgt = CH1;
            SEL_CH2: w_tgt = CH2;
        endcase
    end

    // Ready depends only on the targeted slot, never on in_valid.
    assign in_ready = w_can_push[w_tgt];
    assign w_acc    = in_valid & in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_push[k] = w_acc & (w_tgt == 2'(k));

        b2_demux_slot #(.W(W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_push     (w_push[k]),
            .i_data     (in_data),
            .i_pop      (out_ready[k]),
            .o_valid    (out_valid[k]),
            .o_data     (out_data[k*W +: W]),
            .o_can_push (w_can_push[k])
        );

        // Free-running wrap, no saturation
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt[k] <= '0;
            end else if (w_push[k]) begin
                r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];

endmodule

// File: tb/tb_b2_demux_1_3_stream.sv
// Directed and scoreboarded bench for b2_demux_1_3_stream.
// Inputs change 1 time unit after the rising edge; outputs sampled before the next.
module tb_b2_demux_1_3_stream;

    localparam int W     = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_sel;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [3*W-1:0]   out_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    int n_run;
    int n_fail;

    b2_demux_1_3_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tgt_of(input logic [1:0] s);
        return (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : 2;
    endfunction

    function automatic logic [W-1:0] chd(input logic [3*W-1:0] d, input int k);
        return d[k*W +: W];
    endfunction

    logic [W-1:0] q [3][$];
    logic [W-1:0] exp_w;
    int           exp_cnt [3];
    int           t;
    logic [W-1:0] rd [4];
    logic [1:0]   rs [4];

    initial begin
        n_run    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sel   = 2'b00;
        out_ready = 3'b000;
        step();
        step();
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_od", 32'(out_data), 32'd0);
        check("rst_cnt", {8'd0, cnt2, cnt1, cnt0}, 32'd0);
        rst = 1'b0;

        // Routing with all channels ready
        rd[0] = 2'b01; rs[0] = 2'b00;
        rd[1] = 2'b10; rs[1] = 2'b01;
        rd[2] = 2'b11; rs[2] = 2'b10;
        rd[3] = 2'b00; rs[3] = 2'b11;
        out_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = rd[i];
            in_sel   = rs[i];
            #1;
            check("route_rdy", 32'(in_ready), 32'd1);
            step();
            t = tgt_of(rs[i]);
            check("route_ov", 32'(out_valid[t]), 32'd1);
            check("route_od", 32'(chd(out_data, t)), 32'(rd[i]));
        end
        in_valid = 1'b0;
        step();
        check("route_cnt", {8'd0, cnt2, cnt1, cnt0}, {8'd0, 8'd2, 8'd1, 8'd1});
        check("route_drain", 32'(out_valid), 32'd0);

        // Backpressure on ch0 does not block ch1
        out_ready = 3'b110;
        in_valid = 1'b1; in_data = 2'b11; in_sel = 2'b00;
        #1;
        check("bp_rdy_a", 32'(in_ready), 32'd1);
        step();
        in_data = 2'b01; in_sel = 2'b00;
        #1;
        check("bp_rdy_b", 32'(in_ready), 32'd0);
        step();
        check("bp_hold_ov", 32'(out_valid[0]), 32'd1);
        check("bp_hold_od", 32'(chd(out_data, 0)), 32'd3);
        in_data = 2'b10; in_sel = 2'b01;
        #1;
        check("bp_ch1_rdy", 32'(in_ready), 32'd1);
        step();
        check("bp_ch1_od", 32'(chd(out_data, 1)), 32'd2);
        check("bp_ch1_cnt", 32'(cnt1), 32'd2);
        check("bp_ch0_held", 32'(chd(out_data, 0)), 32'd3);
        in_data = 2'b01; in_sel = 2'b00; out_ready = 3'b111;
        #1;
        check("bp_release", 32'(in_ready), 32'd1);
        step();
        check("bp_new_ov", 32'(out_valid[0]), 32'd1);
        check("bp_new_od", 32'(chd(out_data, 0)), 32'd1);
        check("bp_cnt0", 32'(cnt0), 32'd3);
        in_valid = 1'b0;
        step();

        // Same-cycle push/pop on ch2
        out_ready = 3'b000;
        in_valid = 1'b1; in_data = 2'b01; in_sel = 2'b10;
        step();
        check("pp_full", 32'(out_valid[2]), 32'd1);
        out_ready = 3'b100; in_data = 2'b10;
        #1;
        check("pp_rdy", 32'(in_ready), 32'd1);
        step();
        check("pp_ov", 32'(out_valid[2]), 32'd1);
        check("pp_od", 32'(chd(out_data, 2)), 32'd2);
        check("pp_cnt2", 32'(cnt2), 32'd4);

        // Fill all slots then reset asynchronously between edges
        out_ready = 3'b000;
        in_valid = 1'b1; in_data = 2'b11; in_sel = 2'b00;
        step();
        in_sel = 2'b01;
        step();
        in_valid = 1'b0;
        check("full_ov", 32'(out_valid), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_cnt", {8'd0, cnt2, cnt1, cnt0}, 32'd0);
        step();
        rst = 1'b0;

        // Counter wrap on ch1; ch0 and ch2 hold one count each
        out_ready = 3'b111;
        in_valid = 1'b1; in_data = 2'b00; in_sel = 2'b00;
        step();
        in_sel = 2'b10;
        step();
        in_sel = 2'b01;
        for (int i = 0; i < 255; i++) begin
            in_data = W'(i);
            step();
        end
        check("wrap_255", 32'(cnt1), 32'd255);
        step();
        in_valid = 1'b0;
        check("wrap_0", 32'(cnt1), 32'd0);
        check("wrap_other", {16'd0, cnt2, cnt0}, {16'd0, 8'd1, 8'd1});
        step();

        // Random streaming against per-channel queues
        for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
        exp_cnt[0] = 1; exp_cnt[1] = 0; exp_cnt[2] = 1;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'b1;
            in_data   = W'($urandom_range(0, 3));
            in_sel    = 2'($urandom_range(0, 3));
            out_ready = 3'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < 3; k++)
                check("st_ov", 32'(out_valid[k]), 32'(q[k].size() != 0));
            t = tgt_of(in_sel);
            check("st_rdy", 32'(in_ready),
                  32'((q[t].size() == 0) || out_ready[t]));
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && out_ready[k] && q[k].size() != 0) begin
                    exp_w = q[k].pop_front();
                    check("st_data", 32'(chd(out_data, k)), 32'(exp_w));
                end
            end
            if (in_ready) begin
                q[t].push_back(in_data);
                exp_cnt[t] = (exp_cnt[t] + 1) % 256;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 3'b111;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (out_valid[k] && q[k].size() != 0) begin
                exp_w = q[k].pop_front();
                check("st_tail", 32'(chd(out_data, k)), 32'(exp_w));
            end
        end
        step();
        check("st_empty", 32'(out_valid), 32'd0);
        check("st_left", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
        check("st_cnt0", 32'(cnt0), 32'(exp_cnt[0]));
        check("st_cnt1", 32'(cnt1), 32'(exp_cnt[1]));
        check("st_cnt2", 32'(cnt2), 32'(exp_cnt[2]));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
